// File: rtl/csoc_test_pkg.sv
// Shared constants and mode decode for the CSoC test-port model.
// Imported by the test port and its synchronizer.
package csoc_test_pkg;

  localparam int LANES          = 8;
  localparam int DEF_CHAIN_LEN  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    MODE_FUNC,
    MODE_SHIFT,
    MODE_CAPTURE
  } mode_e;

  function automatic mode_e decode_mode(
    input logic tm,
    input logic se
  );
    if (!tm) return MODE_FUNC;
    return se ? MODE_SHIFT : MODE_CAPTURE;
  endfunction

endpackage

// File: rtl/csoc_sync_edge.sv
// Two-flop synchronizer bank with a rising-edge pulse on bit 0.
// Also used by the parser bench.
module csoc_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [WIDTH-1:0] meta;
  logic             prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q[0];
    end
  end

  // Pulse lasts one clk; the update it triggers lands on the third edge.
  assign rise = q[0] & ~prev;

endmodule

// File: rtl/csoc_test_port.sv
// Chip-side model of the CSoC test port: 8 scan lanes plus a
// byte echo FIFO, all driven from the sampled controller test clock.
module csoc_test_port
  import csoc_test_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csoc_clk,
  input  logic             csoc_rstn,
  input  logic             csoc_test_se,
  input  logic             csoc_test_tm,
  input  logic             csoc_uart_read,
  input  logic [LANES-1:0] csoc_data_i,
  output logic             csoc_uart_write,
  output logic [LANES-1:0] csoc_data_o,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = 5 + LANES;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [SW-1:0]    pins;
  logic [SW-1:0]    sync;
  logic             e;
  logic             rstn_s;
  logic             se_s;
  logic             tm_s;
  logic             rd_s;
  logic [LANES-1:0] data_s;
  logic             unused_cclk;
  mode_e            mode;

  assign pins = {csoc_data_i, csoc_uart_read, csoc_test_tm,
                 csoc_test_se, csoc_rstn, csoc_clk};

  csoc_sync_edge #(
    .WIDTH(SW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins),
    .q   (sync),
    .rise(e)
  );

  assign {data_s, rd_s, tm_s, se_s, rstn_s} = sync[SW-1:1];
  assign unused_cclk = sync[0];
  assign mode = decode_mode(tm_s, se_s);

  logic [CHAIN_LEN-1:0] lane [LANES];
  logic [LANES-1:0]     tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) lane[k] <= '0;
    end else if (!rstn_s) begin
      for (int k = 0; k < LANES; k++) lane[k] <= '0;
    end else if (e) begin
      for (int k = 0; k < LANES; k++) begin
        unique case (mode)
          MODE_SHIFT:
            lane[k] <= {lane[k][CHAIN_LEN-2:0], data_s[k]};
          MODE_CAPTURE:
            lane[k] <= {lane[k][CHAIN_LEN-2:0], ^lane[k]};
          default:
            lane[k] <= lane[k];
        endcase
      end
    end
  end

  always_comb begin
    tail = '0;
    for (int k = 0; k < LANES; k++) tail[k] = lane[k][CHAIN_LEN-1];
  end

  logic [LANES-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [LANES-1:0] out_q;
  logic             write_q;
  logic             ovf_q;
  logic             pop;
  logic             full;
  logic             push_ok;

  // Pushes are taken in either mode; only functional cycles drain.
  always_comb begin
    pop     = (mode == MODE_FUNC) && (count != '0);
    full    = (count == FULL_CNT);
    push_ok = rd_s && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (e && rstn_s && push_ok) mem[wr_ptr] <= data_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_q   <= '0;
      write_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!rstn_s) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_q   <= '0;
      write_q <= 1'b0;
    end else if (e) begin
      write_q <= pop;
      if (pop) begin
        out_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      else if (rd_s) ovf_q <= 1'b1;
      count <= count
             + {{AW{1'b0}}, push_ok}
             - {{AW{1'b0}}, pop};
    end
  end

  assign csoc_data_o     = tm_s ? tail : out_q;
  assign csoc_uart_write = !tm_s && write_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_csoc_test_port.sv
// Directed bench for csoc_test_port with CHAIN_LEN=4, FIFO_DEPTH=4.
// Each step drives one slow test-clock period and checks the outputs.
module tb_csoc_test_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       csoc_clk = 1'b0;
  logic       csoc_rstn = 1'b1;
  logic       csoc_test_se = 1'b0;
  logic       csoc_test_tm = 1'b0;
  logic       csoc_uart_read = 1'b0;
  logic [7:0] csoc_data_i = 8'h00;
  logic       csoc_uart_write;
  logic [7:0] csoc_data_o;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  csoc_test_port #(
    .CHAIN_LEN (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .csoc_clk       (csoc_clk),
    .csoc_rstn      (csoc_rstn),
    .csoc_test_se   (csoc_test_se),
    .csoc_test_tm   (csoc_test_tm),
    .csoc_uart_read (csoc_uart_read),
    .csoc_data_i    (csoc_data_i),
    .csoc_uart_write(csoc_uart_write),
    .csoc_data_o    (csoc_data_o),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic se, input logic tm,
                       input logic rd, input logic [7:0] d);
    csoc_test_se   = se;
    csoc_test_tm   = tm;
    csoc_uart_read = rd;
    csoc_data_i    = d;
    repeat (5) @(negedge clk);
    csoc_clk = 1'b1;
    repeat (6) @(negedge clk);
    csoc_clk = 1'b0;
  endtask

  initial begin
    logic [7:0] shift_exp [8];
    logic [7:0] shift_in  [8];
    logic [7:0] cap_exp   [4];
    shift_in  = '{8'h01, 8'h02, 8'h04, 8'h08,
                  8'h00, 8'h00, 8'h00, 8'h00};
    shift_exp = '{8'h00, 8'h00, 8'h00, 8'h01,
                  8'h02, 8'h04, 8'h08, 8'h00};
    cap_exp   = '{8'hFF, 8'hFF, 8'hFF, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_data", csoc_data_o, 8'h00);
    check("rst_write", {7'd0, csoc_uart_write}, 8'h00);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Scan shift
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 1'b1, 1'b0, shift_in[i]);
      check($sformatf("shift_e%0d", i + 1), csoc_data_o, shift_exp[i]);
    end

    // Capture: load 1011 in every lane, capture, shift out
    pulse(1'b1, 1'b1, 1'b0, 8'hFF);
    pulse(1'b1, 1'b1, 1'b0, 8'h00);
    pulse(1'b1, 1'b1, 1'b0, 8'hFF);
    pulse(1'b1, 1'b1, 1'b0, 8'hFF);
    check("cap_load", csoc_data_o, 8'hFF);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    check("cap_tail0", csoc_data_o, 8'h00);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("cap_out%0d", i + 1), csoc_data_o, cap_exp[i]);
    end

    // Echo
    pulse(1'b0, 1'b0, 1'b1, 8'hA5);
    check("echo_e1_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("echo_e1_data", csoc_data_o, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("echo_e2_wr", {7'd0, csoc_uart_write}, 8'h01);
    check("echo_e2_data", csoc_data_o, 8'hA5);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("echo_e3_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("echo_e3_data", csoc_data_o, 8'hA5);

    // Output mux follows tm without a test-clock edge
    csoc_test_tm = 1'b1;
    repeat (4) @(negedge clk);
    check("mux_tm1", csoc_data_o, 8'h00);
    csoc_test_tm = 1'b0;
    repeat (4) @(negedge clk);
    check("mux_tm0", csoc_data_o, 8'hA5);

    // Streaming pushes with pops: never fills
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
      if (i == 0) begin
        check("strm_e1_wr", {7'd0, csoc_uart_write}, 8'h00);
      end else begin
        check($sformatf("strm_e%0d", i + 1), csoc_data_o, 8'h10 + 8'(i - 1));
        check($sformatf("strm_wr%0d", i + 1), {7'd0, csoc_uart_write}, 8'h01);
      end
    end
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("strm_e6", csoc_data_o, 8'h14);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("strm_e7_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("strm_ovf", {7'd0, overflow}, 8'h00);

    // Fill in test mode (no pops), fifth push overflows
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b1, 1'b1, 8'h10 + 8'(i));
      if (i == 3) check("fill_ovf4", {7'd0, overflow}, 8'h00);
    end
    check("fill_ovf5", {7'd0, overflow}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("drain%0d", i), csoc_data_o, 8'h10 + 8'(i));
      check($sformatf("drain_wr%0d", i), {7'd0, csoc_uart_write}, 8'h01);
    end
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("drain_empty_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("drain_hold", csoc_data_o, 8'h13);

    // Chip reset mid-shift and mid-echo
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b1, 1'b0, 8'hFF);
    check("crst_pre_tail", csoc_data_o, 8'hFF);
    pulse(1'b0, 1'b0, 1'b1, 8'h5A);
    pulse(1'b0, 1'b0, 1'b1, 8'h6B);
    check("crst_pre_echo", csoc_data_o, 8'h5A);
    csoc_rstn = 1'b0;
    repeat (4) @(negedge clk);
    check("crst_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("crst_data", csoc_data_o, 8'h00);
    check("crst_ovf_kept", {7'd0, overflow}, 8'h01);
    pulse(1'b0, 1'b0, 1'b1, 8'h77);
    check("crst_ign_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("crst_ign_data", csoc_data_o, 8'h00);
    csoc_test_tm = 1'b1;
    repeat (4) @(negedge clk);
    check("crst_chains", csoc_data_o, 8'h00);
    csoc_test_tm = 1'b0;
    csoc_rstn = 1'b1;
    repeat (4) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("crst_fifo1_wr", {7'd0, csoc_uart_write}, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("crst_fifo2_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("crst_fifo2_data", csoc_data_o, 8'h00);

    // Board reset mid-traffic
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b1, 1'b0, 8'hFF);
    pulse(1'b0, 1'b0, 1'b1, 8'h3C);
    pulse(1'b0, 1'b0, 1'b0, 8'h00);
    check("brst_pre_data", csoc_data_o, 8'h3C);
    rst = 1'b1;
    #1;
    check("brst_data", csoc_data_o, 8'h00);
    check("brst_wr", {7'd0, csoc_uart_write}, 8'h00);
    check("brst_ovf", {7'd0, overflow}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("brst_chain%0d", i), csoc_data_o, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csoc_test_port.md
Name: csoc_test_port

Overview:
- FPGA-side model of the CSoC test port: the chip end of the scan/data interface that the UART command parser drives.
- Runs on the board clock, samples the parser's csoc_clk/csoc_rstn as slow asynchronous signals, and implements two modes:
  - 8 parallel scan chains (test mode).
  - A byte echo FIFO (functional mode).
- Instantiated in the loopback build and the bench in place of silicon, so controller firmware and ATPG flows close end-to-end.

Parameters:
- CHAIN_LEN, 16, bits per scan lane (≥2); 8 lanes, one per data bit.
- FIFO_DEPTH, 4, functional echo FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  board clock.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- csoc_clk  in  1  test clock from controller; sampled, never used as a clock.
- csoc_rstn  in  1  chip reset, active low, from controller.
- csoc_test_se  in  1  scan enable.
- csoc_test_tm  in  1  test mode (1 = scan, 0 = functional).
- csoc_uart_read  in  1  controller offers csoc_data_i to chip at next csoc_clk rise.
- csoc_data_i  in  8  scan-in lanes / functional write byte.
- csoc_uart_write  out  1  chip byte valid on csoc_data_o for current csoc_clk period.
- csoc_data_o  out  8  scan-out lanes / functional read byte.
- overflow  out  1  sticky: push attempted while FIFO full.

Behaviour:
- rst: all chains 0, FIFO empty, csoc_uart_write=0, csoc_data_o=0, overflow=0, synchronizers 0.
- Synchronization:
  - csoc_clk, csoc_rstn, se, tm, uart_read, data_i each pass through 2 flops.
  - Event E = synchronized csoc_clk 0->1, one clk pulse, 3 clk after the pin rises.
  - All state updates occur only on E, using the synchronized se/tm/uart_read/data_i values at E.
  - Controller holds csoc_clk high and low ≥4 clk each and keeps other inputs stable ±4 clk around the rise; no checking.
- Chip reset: synchronized csoc_rstn=0 clears chains, FIFO, csoc_uart_write, csoc_data_o; overflow is NOT cleared (only rst clears it). While low, E is ignored. Mid-shift or mid-echo reset discards all data.
- Scan shift (tm=1, se=1, on E), per lane k:
  - lane[k] <= {lane[k][CHAIN_LEN-2:0], data_i[k]}.
  - Tail bit is lane[k][CHAIN_LEN-1].
  - A bit shifted in appears at the tail after CHAIN_LEN E's.
- Capture (tm=1, se=0, on E), per lane:
  - lane <= {lane[CHAIN_LEN-2:0], ^lane}, i.e. shift left with the XOR of all lane bits as the new LSB.
- Test-mode outputs (tm=1):
  - csoc_data_o[k] = lane[k][CHAIN_LEN-1], combinational from registers; updates 1 clk after E.
  - csoc_uart_write=0.
  - The FIFO holds its contents.
- Functional mode (tm=0), on E, evaluated on pre-E state:
  - Pop: if FIFO non-empty, the output register loads the head byte, csoc_uart_write <= 1, and the entry is removed. If empty, csoc_uart_write <= 0 and the output register holds its value.
  - Push: if uart_read=1, data_i is written to the tail. If the FIFO is full (pre-E count == FIFO_DEPTH and no pop this E), the byte is dropped and overflow <= 1.
  - Simultaneous pop and push at full: pop frees an entry and the push succeeds.
  - Latency: a byte pushed at E_n is presented at E_{n+1} at the earliest; bytes are presented in FIFO order.
  - csoc_uart_write stays high for the whole csoc_clk period until the next E.
  - csoc_data_o = output register.
- Mode switch:
  - tm sampled at E selects the operation; chains and FIFO are independent state.
  - csoc_data_o mux follows synchronized tm immediately, with no E required.
- Count: log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package csoc_test_pkg holds:
  - LANES=8.
  - Default CHAIN_LEN and FIFO_DEPTH.
  - Mode enum {MODE_FUNC, MODE_SHIFT, MODE_CAPTURE} decoded from tm/se.
- Sub-module csoc_sync_edge: 2-flop synchronizer plus rising-edge detect. Parameterized width; the edge output is used for csoc_clk only. It is reused by the parser bench.

Test Plan:
- Reset: assert rst mid-traffic -> all outputs 0 within 1 clk, overflow=0, chains read back all 0 after 16 shifts.
- Shift (CHAIN_LEN=4), tm=1, se=1: drive data_i=0x01,0x02,0x04,0x08 then 0x00 x4 -> data_o=0x00 for the first 3 E's; 0x01,0x02,0x04,0x08 after E4..E7.
- Capture, CHAIN_LEN=4: load each lane with 0b1011, one E with se=0 -> lanes=0b0111 (XOR=1), data_o=0x00; shift out -> bits 0,1,1,1 per lane in tail order.
- Echo, tm=0: uart_read=1 with 0xA5 at E1, then uart_read=0 -> at E2 csoc_uart_write=1, data_o=0xA5; at E3 csoc_uart_write=0, data_o stays 0xA5.
- Overflow, FIFO_DEPTH=4: push 0x10..0x14 on consecutive E's with pops starting at E2 -> no overflow. Repeat from empty with tm toggled to 1 between pushes so nothing pops, 5 pushes -> overflow=1, 5th byte lost, later pops return 0x10..0x13.
- csoc_rstn low mid-shift and mid-echo -> chains and FIFO cleared, csoc_uart_write=0, E ignored while low, overflow retained.
